// File: rtl/mem_req_responder.sv
// mem_req_responder: single-outstanding memory responder with a word store
// and a direct-mapped tag/valid tracker that sets hit/miss latency.
// Ports: clk, rst (sync, active-low); Addr/DataIn/Rd/Wr request inputs;
// DataOut read data, Done completion pulse, Stall busy, CacheHit hit
// qualifier on Done, Err pulse for an illegal Rd&Wr request.
module mem_req_responder #(
    parameter int MEM_AW   = 15,
    parameter int OFF_W    = 3,
    parameter int IDX_W    = 8,
    parameter int MISS_LAT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] Addr,
    input  logic [15:0] DataIn,
    input  logic        Rd,
    input  logic        Wr,
    output logic [15:0] DataOut,
    output logic        Done,
    output logic        Stall,
    output logic        CacheHit,
    output logic        Err
);

    localparam int TAG_W = 16 - IDX_W - OFF_W;
    localparam int LINES = 1 << IDX_W;
    localparam int WORDS = 1 << MEM_AW;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MISS = 1'b1;

    localparam logic [4:0] CNT_INIT = 5'(MISS_LAT - 1);

    logic [0:0]       state;
    logic [4:0]       cnt;
    logic [15:0]      mem  [WORDS];
    logic [TAG_W-1:0] tags [LINES];
    logic [LINES-1:0] valid;

    logic [MEM_AW-1:0] req_word;
    logic [IDX_W-1:0]  req_idx;
    logic [TAG_W-1:0]  req_tag;
    logic [15:0]       req_data;
    logic              req_wr;

    logic [MEM_AW-1:0] in_word;
    logic [IDX_W-1:0]  in_idx;
    logic [TAG_W-1:0]  in_tag;
    logic              unused_addr;

    logic idle;
    logic accept;
    logic illegal;
    logic hit;
    logic miss_done;

    logic              mem_we;
    logic [MEM_AW-1:0] mem_wa;
    logic [15:0]       mem_wd;
    logic              fill;

    // Byte address -> word index; bit 0 selects nothing in a 16-bit store.
    assign in_word     = Addr[MEM_AW:1];
    assign in_idx      = Addr[OFF_W+IDX_W-1:OFF_W];
    assign in_tag      = Addr[15:16-TAG_W];
    assign unused_addr = Addr[0];

    assign idle      = (state == IDLE);
    assign accept    = idle && (Rd ^ Wr);
    assign illegal   = idle && Rd && Wr;
    assign hit       = valid[in_idx] && (tags[in_idx] == in_tag);
    assign miss_done = (state == MISS) && (cnt == 5'd0);

    assign Stall = (state == MISS);

    // A hit write commits at acceptance; a miss write commits when the
    // miss completes. Reset suppresses both, so an aborted miss leaves
    // no trace in the store or tracker.
    assign mem_we = rst && ((accept && hit && Wr) ||
                            (miss_done && req_wr));
    assign mem_wa = miss_done ? req_word : in_word;
    assign mem_wd = miss_done ? req_data : DataIn;
    assign fill   = rst && miss_done;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tags[req_idx] <= req_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            valid    <= '0;
            Done     <= 1'b0;
            CacheHit <= 1'b0;
            Err      <= 1'b0;
            DataOut  <= 16'h0000;
            req_word <= '0;
            req_idx  <= '0;
            req_tag  <= '0;
            req_data <= 16'h0000;
            req_wr   <= 1'b0;
        end else begin
            Done     <= 1'b0;
            CacheHit <= 1'b0;
            Err      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        req_word <= in_word;
                        req_idx  <= in_idx;
                        req_tag  <= in_tag;
                        req_data <= DataIn;
                        req_wr   <= Wr;
                        if (hit) begin
                            Done     <= 1'b1;
                            CacheHit <= 1'b1;
                            if (!Wr) begin
                                DataOut <= mem[in_word];
                            end
                        end else begin
                            state <= MISS;
                            cnt   <= CNT_INIT;
                        end
                    end else if (illegal) begin
                        Err <= 1'b1;
                    end
                end
                MISS: begin
                    // Done lands in the first IDLE cycle after the miss,
                    // so a follow-on request can be taken at its end.
                    if (cnt == 5'd0) begin
                        state          <= IDLE;
                        valid[req_idx] <= 1'b1;
                        Done           <= 1'b1;
                        if (!req_wr) begin
                            DataOut <= mem[req_word];
                        end
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_responder.sv
// tb_mem_req_responder: directed and random checks of mem_req_responder
// latency, data, hit flag, Err and reset behaviour.
module tb_mem_req_responder;

    logic        clk;
    logic        rst;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        Err;

    int vectors;
    int fails;

    logic [15:0] mm [0:32767];
    logic        mv [0:255];
    logic [4:0]  mt [0:255];

    mem_req_responder dut (
        .clk      (clk),
        .rst      (rst),
        .Addr     (Addr),
        .DataIn   (DataIn),
        .Rd       (Rd),
        .Wr       (Wr),
        .DataOut  (DataOut),
        .Done     (Done),
        .Stall    (Stall),
        .CacheHit (CacheHit),
        .Err      (Err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Called at a negedge; presents the request, removes it after the
    // acceptance edge, and waits (bounded) for Done.
    task automatic do_req(input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d,
                          output int lat, output int stalls,
                          output logic [15:0] dout, output logic hit,
                          output logic st);
        logic seen;
        seen = 1'b0;
        lat = 0;
        stalls = 0;
        dout = 16'hxxxx;
        hit = 1'bx;
        st = 1'bx;
        Rd = r;
        Wr = w;
        Addr = a;
        DataIn = d;
        @(posedge clk);
        #1;
        Rd = 1'b0;
        Wr = 1'b0;
        Addr = 16'($urandom);
        DataIn = 16'($urandom);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (Stall) stalls++;
            if (Done) begin
                dout = DataOut;
                hit = CacheHit;
                st = Stall;
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            vectors++;
            fails++;
            $display("FAIL req_timeout addr=%h got no Done need Done", a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        Rd = 1'b0;
        Wr = 1'b0;
        Addr = 16'h0;
        DataIn = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({Done, Stall, CacheHit, Err} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_flags got %b need 0000",
                     {Done, Stall, CacheHit, Err});
        end
        vectors++;
        if (DataOut !== 16'h0000) begin
            fails++;
            $display("FAIL reset_dataout got %h need 0000", DataOut);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({Done, Stall, CacheHit, Err} !== 4'b0000) begin
            fails++;
            $display("FAIL idle_flags got %b need 0000",
                     {Done, Stall, CacheHit, Err});
        end
    endtask

    task automatic test_first_miss();
        int lat, stl;
        logic [15:0] dout;
        logic hit, st;
        do_req(1'b1, 1'b0, 16'h0040, 16'h0, lat, stl, dout, hit, st);
        vectors++;
        if (stl !== 8) begin
            fails++;
            $display("FAIL miss_stall_cycles got %0d need 8", stl);
        end
        vectors++;
        if (lat !== 9) begin
            fails++;
            $display("FAIL miss_latency got %0d need 9", lat);
        end
        vectors++;
        if (hit !== 1'b0 || st !== 1'b0) begin
            fails++;
            $display("FAIL miss_flags got hit=%b stall=%b need 0 0", hit, st);
        end
        vectors++;
        if (dout !== 16'h0000) begin
            fails++;
            $display("FAIL miss_data got %h need 0000", dout);
        end
    endtask

    task automatic test_hit();
        int lat, stl;
        logic [15:0] dout;
        logic hit, st;
        do_req(1'b0, 1'b1, 16'h0040, 16'hBEEF, lat, stl, dout, hit, st);
        vectors++;
        if (lat !== 1 || hit !== 1'b1) begin
            fails++;
            $display("FAIL wr_hit got lat=%0d hit=%b need 1 1", lat, hit);
        end
        do_req(1'b1, 1'b0, 16'h0040, 16'h0, lat, stl, dout, hit, st);
        vectors++;
        if (lat !== 1 || hit !== 1'b1) begin
            fails++;
            $display("FAIL rd_hit got lat=%0d hit=%b need 1 1", lat, hit);
        end
        vectors++;
        if (dout !== 16'hBEEF) begin
            fails++;
            $display("FAIL rd_hit_data got %h need BEEF", dout);
        end
    endtask

    task automatic test_back_to_back();
        int lat, stl;
        logic [15:0] dout;
        logic hit, st;
        do_req(1'b0, 1'b1, 16'h0041, 16'h1111, lat, stl, dout, hit, st);
        do_req(1'b1, 1'b0, 16'h0040, 16'h0, lat, stl, dout, hit, st);
        vectors++;
        if (lat !== 1 || dout !== 16'h1111) begin
            fails++;
            $display("FAIL b2b got lat=%0d data=%h need 1 1111", lat, dout);
        end
    endtask

    task automatic test_conflict();
        int lat, stl;
        logic [15:0] dout;
        logic hit, st;
        do_req(1'b0, 1'b1, 16'h0808, 16'h1234, lat, stl, dout, hit, st);
        vectors++;
        if (lat !== 9 || hit !== 1'b0) begin
            fails++;
            $display("FAIL conf_wr got lat=%0d hit=%b need 9 0", lat, hit);
        end
        do_req(1'b1, 1'b0, 16'h0008, 16'h0, lat, stl, dout, hit, st);
        vectors++;
        if (lat !== 9 || dout !== 16'h0000) begin
            fails++;
            $display("FAIL conf_rd0 got lat=%0d data=%h need 9 0000",
                     lat, dout);
        end
        do_req(1'b1, 1'b0, 16'h0808, 16'h0, lat, stl, dout, hit, st);
        vectors++;
        if (lat !== 9 || dout !== 16'h1234) begin
            fails++;
            $display("FAIL conf_rd1 got lat=%0d data=%h need 9 1234",
                     lat, dout);
        end
    endtask

    task automatic test_err();
        int lat, stl;
        logic [15:0] dout;
        logic hit, st;
        Rd = 1'b1;
        Wr = 1'b1;
        Addr = 16'h0010;
        DataIn = 16'hAAAA;
        @(posedge clk);
        #1;
        Rd = 1'b0;
        Wr = 1'b0;
        @(negedge clk);
        vectors++;
        if ({Err, Done, Stall} !== 3'b100) begin
            fails++;
            $display("FAIL err_pulse got %b need 100", {Err, Done, Stall});
        end
        @(negedge clk);
        vectors++;
        if (Err !== 1'b0) begin
            fails++;
            $display("FAIL err_width got %b need 0", Err);
        end
        do_req(1'b1, 1'b0, 16'h0010, 16'h0, lat, stl, dout, hit, st);
        vectors++;
        if (lat !== 9 || hit !== 1'b0 || dout !== 16'h0000) begin
            fails++;
            $display("FAIL err_after got lat=%0d hit=%b data=%h need 9 0 0",
                     lat, hit, dout);
        end
    endtask

    task automatic test_reset_abort();
        int lat, stl;
        logic [15:0] dout;
        logic hit, st;
        logic saw;
        saw = 1'b0;
        Wr = 1'b1;
        Addr = 16'h2000;
        DataIn = 16'h5555;
        @(posedge clk);
        #1;
        Wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (Done) saw = 1'b1;
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        vectors++;
        if (Stall !== 1'b0) begin
            fails++;
            $display("FAIL abort_stall got %b need 0", Stall);
        end
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (Done) saw = 1'b1;
        end
        vectors++;
        if (saw !== 1'b0) begin
            fails++;
            $display("FAIL abort_done got %b need 0", saw);
        end
        do_req(1'b1, 1'b0, 16'h2000, 16'h0, lat, stl, dout, hit, st);
        vectors++;
        if (lat !== 9 || dout !== 16'h0000) begin
            fails++;
            $display("FAIL abort_rd got lat=%0d data=%h need 9 0000",
                     lat, dout);
        end
    endtask

    task automatic test_random();
        int lat, stl, elat;
        logic [15:0] dout, a, d;
        logic hit, st, w, ehit;
        logic [7:0] idx;
        logic [4:0] tg;
        for (int i = 0; i < 32768; i++) mm[i] = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            mv[i] = 1'b0;
            mt[i] = 5'd0;
        end
        mm[15'h0020] = 16'hBEEF;
        mm[15'h0020] = 16'h1111;
        mm[15'h0404] = 16'h1234;
        for (int n = 0; n < 1000; n++) begin
            tg = 5'($urandom_range(0, 2));
            idx = 8'($urandom_range(0, 9));
            a = {tg, idx, 3'($urandom)};
            d = 16'($urandom);
            w = 1'($urandom);
            ehit = mv[idx] && (mt[idx] == tg);
            elat = ehit ? 1 : 9;
            do_req(!w, w, a, d, lat, stl, dout, hit, st);
            vectors++;
            if (lat !== elat || hit !== ehit) begin
                fails++;
                $display("FAIL rnd_lat a=%h got %0d/%b need %0d/%b",
                         a, lat, hit, elat, ehit);
            end
            vectors++;
            if (st !== 1'b0) begin
                fails++;
                $display("FAIL rnd_stall a=%h got %b need 0", a, st);
            end
            if (!w) begin
                vectors++;
                if (dout !== mm[a[15:1]]) begin
                    fails++;
                    $display("FAIL rnd_data a=%h got %h need %h",
                             a, dout, mm[a[15:1]]);
                end
            end else begin
                mm[a[15:1]] = d;
            end
            mv[idx] = 1'b1;
            mt[idx] = tg;
        end
    endtask

    initial begin
        vectors = 0;
        fails = 0;
        test_reset();
        test_first_miss();
        test_hit();
        test_back_to_back();
        test_conflict();
        test_err();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, fails);
        $finish;
    end

endmodule
